boot_loader: RTL and testbench

- Byte-stream program loader upstream of the multicycle CPU. It receives a framed image from the serial receiver and writes it word-by-word into unified memory through the memory write port.
- It holds the CPU in reset until a frame has fully loaded and its checksum matches, then releases the CPU to fetch from address 0.
- On a bad frame it keeps the CPU in reset and flags an error.

---
 rtl/loader_pkg.sv | 18 +
 rtl/word_assembler.sv | 35 +++
 rtl/boot_loader.sv | 148 ++++++++++++++
 tb/tb_boot_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding, default frame
// sync byte and the frame length-header width.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    RUN    = 3'd5,
    ERROR  = 3'd6
  } state_e;

  localparam logic [7:0]  SYNC_DEF = 8'hA5;
  localparam int unsigned HDR_W    = 16;

endpackage

// File: rtl/word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; the completed word is held
// in its own register so the shift register can take the next byte at once.
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_ready_o,
  output logic [31:0] word_o
);

  logic [23:0] shift_q;
  logic [1:0]  idx_q;
  logic [31:0] word_q;

  assign word_ready_o = valid_i && (idx_q == 2'd3);
  assign word_o       = word_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      idx_q   <= '0;
      word_q  <= '0;
    end else if (clr_i) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (valid_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      idx_q   <= idx_q + 2'd1;
      if (idx_q == 2'd3) word_q <= {shift_q, byte_i};
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Framed image loader: writes received words to memory and releases the CPU
// from reset only after a complete frame with a matching XOR checksum.
module boot_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned TIMEOUT   = 100000,
  parameter logic [7:0]  SYNC      = SYNC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic [7:0]        len_hi_q;
  logic [HDR_W-1:0]  len_q;
  logic [HDR_W-1:0]  word_idx_q;
  logic [7:0]        csum_q;
  logic [GAP_W-1:0]  gap_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              cpu_rst_q;
  logic              done_q;
  logic              err_q;

  logic [HDR_W-1:0]  len_d;
  logic [HDR_W-1:0]  word_idx_d;
  logic              busy;
  logic              timeout_hit;
  logic              asm_valid;
  logic              asm_clr;
  logic              word_ready;
  logic [31:0]       word;

  assign len_d       = {len_hi_q, rx_data};
  assign word_idx_d  = word_idx_q + HDR_W'(1);
  assign busy        = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                       (state_q == DATA)   || (state_q == CHK);
  assign timeout_hit = busy && !rx_valid && (gap_q == GAP_W'(TIMEOUT - 1));
  assign asm_valid   = rx_valid && (state_q == DATA);
  assign asm_clr     = rx_valid && (state_q == LEN_LO);

  word_assembler u_asm (
    .clk_i        (clk),
    .rst_i        (rst),
    .clr_i        (asm_clr),
    .valid_i      (asm_valid),
    .byte_i       (rx_data),
    .word_ready_o (word_ready),
    .word_o       (word)
  );

  // The last word's write strobe lands in the first CHK cycle, so a checksum
  // byte sent back-to-back with the payload is never mistaken for data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_hi_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      csum_q     <= '0;
      gap_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (timeout_hit) begin
        state_q <= ERROR;
        err_q   <= 1'b1;
        gap_q   <= '0;
      end else begin
        if (busy && !rx_valid) gap_q <= gap_q + GAP_W'(1);
        else                   gap_q <= '0;
        if (rx_valid) begin
          unique case (state_q)
            IDLE: if (rx_data == SYNC) state_q <= LEN_HI;
            LEN_HI: begin
              len_hi_q <= rx_data;
              state_q  <= LEN_LO;
            end
            LEN_LO: begin
              len_q      <= len_d;
              word_idx_q <= '0;
              csum_q     <= '0;
              if (len_d > HDR_W'(MAX_WORDS)) begin
                state_q <= ERROR;
                err_q   <= 1'b1;
              end else if (len_d == '0) begin
                state_q <= CHK;
              end else begin
                state_q <= DATA;
              end
            end
            DATA: begin
              csum_q <= csum_q ^ rx_data;
              if (word_ready) begin
                mem_we_q   <= 1'b1;
                mem_addr_q <= ADDR_W'({word_idx_q, 2'b00});
                word_idx_q <= word_idx_d;
                if (word_idx_d == len_q) state_q <= CHK;
              end
            end
            CHK: begin
              if (rx_data == csum_q) begin
                state_q   <= RUN;
                cpu_rst_q <= 1'b0;
                done_q    <= 1'b1;
              end else begin
                state_q <= ERROR;
                err_q   <= 1'b1;
              end
            end
            RUN: ;
            ERROR: begin
              if (rx_data == SYNC) begin
                state_q <= LEN_HI;
                err_q   <= 1'b0;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = word;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: good/bad frames, junk, oversize header,
// inter-byte timeout and a full back-to-back 256-word image.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [9:0]  waddr[$];
  logic [31:0] wdata[$];

  boot_loader #(
    .ADDR_W    (10),
    .MAX_WORDS (256),
    .TIMEOUT   (50),
    .SYNC      (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      waddr.push_back(mem_addr);
      wdata.push_back(mem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    waddr.delete();
    wdata.delete();
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'(k * 7 + k / 256 + 3);
  endfunction

  logic [7:0]  good[12];
  logic [7:0]  csum;
  logic [31:0] w;

  initial begin
    // Payload XOR is 12^34^56^78^9A^BC^DE^F0 = 00
    good = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
             8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};

    idle(3);
    rst = 1'b0;
    idle(5);
    check("reset_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_addr", 32'(mem_addr), 32'd0);
    check("reset_wdata", mem_wdata, 32'd0);
    check("reset_writes", waddr.size(), 0);

    for (int i = 0; i < 12; i++) send(good[i]);
    idle(2);
    check("good_writes", waddr.size(), 2);
    if (waddr.size() == 2) begin
      check("good_addr0", 32'(waddr[0]), 32'h000);
      check("good_data0", wdata[0], 32'h12345678);
      check("good_addr1", 32'(waddr[1]), 32'h004);
      check("good_data1", wdata[1], 32'h9ABCDEF0);
    end
    check("good_done", 32'(done), 32'd1);
    check("good_cpu_rst", 32'(cpu_rst), 32'd0);
    check("good_err", 32'(err), 32'd0);
    send(8'hA5);
    send(8'h00);
    idle(2);
    check("run_ignores_rx", 32'(done), 32'd1);

    do_reset();
    for (int i = 0; i < 11; i++) send(good[i]);
    send(8'h09);
    idle(2);
    check("bad_writes", waddr.size(), 2);
    check("bad_err", 32'(err), 32'd1);
    check("bad_cpu_rst", 32'(cpu_rst), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    send(8'hA5);
    idle(1);
    check("recover_err_clear", 32'(err), 32'd0);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    idle(2);
    check("recover_done", 32'(done), 32'd1);
    check("recover_cpu_rst", 32'(cpu_rst), 32'd0);
    check("recover_writes", waddr.size(), 2);

    do_reset();
    send(8'h11);
    send(8'h22);
    idle(2);
    check("junk_err", 32'(err), 32'd0);
    send(8'hA5);
    send(8'h01);
    send(8'h01);
    idle(1);
    check("oversize_err", 32'(err), 32'd1);
    check("oversize_cpu_rst", 32'(cpu_rst), 32'd1);
    check("oversize_writes", waddr.size(), 0);

    do_reset();
    send(8'hA5);
    send(8'h00);
    send(8'h01);
    send(8'h12);
    send(8'h34);
    idle(44);
    check("timeout_not_yet", 32'(err), 32'd0);
    idle(10);
    check("timeout_err", 32'(err), 32'd1);
    check("timeout_writes", waddr.size(), 0);

    do_reset();
    send(8'hA5);
    send(8'h00);
    send(8'h00);
    send(8'h12);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    check("midreset_err", 32'(err), 32'd0);
    check("midreset_cpu_rst", 32'(cpu_rst), 32'd1);
    send(8'h00);
    idle(60);
    check("midreset_idle_no_timeout", 32'(err), 32'd0);

    do_reset();
    csum = '0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    @(negedge clk);
    rx_data  = 8'h01;
    @(negedge clk);
    rx_data  = 8'h00;
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk);
      rx_data = pat(k);
      csum ^= pat(k);
    end
    @(negedge clk);
    rx_data = csum;
    @(negedge clk);
    rx_valid = 1'b0;
    idle(2);
    check("b2b_writes", waddr.size(), 256);
    if (waddr.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        w = {pat(4*i), pat(4*i+1), pat(4*i+2), pat(4*i+3)};
        check($sformatf("b2b_addr%0d", i), 32'(waddr[i]), 32'(i * 4));
        check($sformatf("b2b_data%0d", i), wdata[i], w);
      end
      check("b2b_last_addr", 32'(waddr[255]), 32'h3FC);
    end
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
